// File: rtl/ac_serial_nch.sv
// Multi-lane bit-serial activation accumulator: one partial sum per bit-plane, MSB-first,
// folded into a full-precision signed dot-product per lane with valid/ready on both sides.
module ac_serial_nch_lane #(
    parameter int IW = 6,
    parameter int OW = 14
) (
    input  logic          first,
    input  logic          step,
    input  logic          neg,
    input  logic [IW-1:0] ps,
    input  logic [OW-1:0] acc_q,
    output logic [OW-1:0] acc_d
);
    logic [OW-1:0] ps_x;

    always_comb begin
        ps_x  = {{(OW-IW){ps[IW-1]}}, ps};
        acc_d = acc_q;
        // The MSB plane of a two's-complement activation carries negative weight.
        if (first)     acc_d = neg ? (~ps_x + OW'(1)) : ps_x;
        else if (step) acc_d = {acc_q[OW-2:0], 1'b0} + ps_x;
    end
endmodule

module ac_serial_nch #(
    parameter int M      = 16,
    parameter int PA_MAX = 8,
    parameter int NCH    = 4,
    parameter int IW     = $clog2(M) + 2,
    parameter int OW     = IW + PA_MAX,
    parameter int CW     = $clog2(PA_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     cfg_pa,
    input  logic              cfg_signed,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NCH*IW-1:0] in_ps,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH*OW-1:0] out_acc,
    output logic              busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [CW-1:0]               pa_q, pa_d, cnt_q, cnt_d, pa_clamp;
    logic                        sgn_q, sgn_d;
    logic [NCH-1:0][OW-1:0]      acc_q, acc_d, lane_nxt;
    logic                        beat, first, step;

    assign in_ready  = (state_q != S_DONE) || out_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_acc   = acc_q;
    assign beat      = in_valid && in_ready;
    // In DONE a beat implies out_ready, so the retire and the new first beat share a cycle.
    assign first     = beat && (state_q != S_ACC);
    assign step      = beat && (state_q == S_ACC);

    always_comb begin
        pa_clamp = cfg_pa;
        if (cfg_pa == '0)               pa_clamp = CW'(1);
        else if (cfg_pa > CW'(PA_MAX))  pa_clamp = CW'(PA_MAX);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        ac_serial_nch_lane #(.IW(IW), .OW(OW)) u_lane (
            .first (first),
            .step  (step),
            .neg   (cfg_signed),
            .ps    (in_ps[i*IW +: IW]),
            .acc_q (acc_q[i]),
            .acc_d (lane_nxt[i])
        );
    end

    always_comb begin
        state_d = state_q;
        pa_d    = pa_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        acc_d   = lane_nxt;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (first) begin
            pa_d    = pa_clamp;
            sgn_d   = cfg_signed;
            cnt_d   = CW'(1);
            state_d = (pa_clamp == CW'(1)) ? S_DONE : S_ACC;
        end else if (step) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == pa_q) state_d = S_DONE;
        end else if (state_q == S_DONE && out_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pa_q    <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pa_q    <= pa_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end
endmodule
